// File: rtl/decoder_scan.sv
// decoder_scan
//   Debounced code-to-one-hot decoder with an auto-scan mode.
//   A raw switch code is synchronized, debounced, and decoded into a
//   registered one-hot output. In scan mode the index instead steps through
//   every output, one step per SCAN_PERIOD cycles.
//
// Ports
//   i_Clk      system clock, rising edge
//   i_Rst      synchronous active-high reset
//   i_Code     raw switch code (asynchronous, may bounce)
//   i_Mode     0 = decode debounced code, 1 = auto-scan
//   i_Enable   1 = outputs active, 0 = one-hot output dark
//   o_One_Hot  registered one-hot decode of o_Index
//   o_Index    registered index currently decoded
//   o_Change   one-cycle pulse whenever o_One_Hot takes a new value
module decoder_scan #(
    parameter int CODE_WIDTH      = 2,
    parameter int OUTPUTS         = 2**CODE_WIDTH,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SCAN_PERIOD     = 12500000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [CODE_WIDTH-1:0] i_Code,
    input  logic                  i_Mode,
    input  logic                  i_Enable,
    output logic [OUTPUTS-1:0]    o_One_Hot,
    output logic [CODE_WIDTH-1:0] o_Index,
    output logic                  o_Change
);

    // Counter widths: the debounce counter must hold DEBOUNCE_CYCLES-1,
    // the prescaler must hold SCAN_PERIOD-1.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = $clog2(SCAN_PERIOD);

    typedef enum logic {
        DECODE = 1'b0,
        SCAN   = 1'b1
    } state_t;

    function automatic logic [OUTPUTS-1:0] onehot_of(input logic [CODE_WIDTH-1:0] idx);
        logic [OUTPUTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [CODE_WIDTH-1:0] code_sync_p0;
    logic [CODE_WIDTH-1:0] code_sync_p1;
    logic [CODE_WIDTH-1:0] accepted_code;
    logic [CODE_WIDTH-1:0] accepted_next;
    logic [DB_W-1:0]       db_cnt;
    logic [DB_W-1:0]       db_cnt_next;

    state_t                state;
    state_t                state_next;
    logic [CODE_WIDTH-1:0] scan_idx;
    logic [CODE_WIDTH-1:0] scan_next;
    logic [PS_W-1:0]       presc;
    logic [PS_W-1:0]       presc_next;
    logic [CODE_WIDTH-1:0] idx_target;
    logic [CODE_WIDTH-1:0] index_next;
    logic [OUTPUTS-1:0]    one_hot_next;

    // Stage p0/p1: two-flop synchronizer on the raw code
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            code_sync_p0 <= '0;
            code_sync_p1 <= '0;
        end else begin
            code_sync_p0 <= i_Code;
            code_sync_p1 <= code_sync_p0;
        end
    end

    // Debounce: p0 differing from p1 means the synchronized code changes on
    // the next edge, so the stable run restarts here. Counting starts on the
    // first cycle p1 holds a new code, giving acceptance DEBOUNCE_CYCLES
    // edges after p1 loads it.
    always_comb begin
        db_cnt_next   = db_cnt;
        accepted_next = accepted_code;
        if ((code_sync_p1 == accepted_code) || (code_sync_p0 != code_sync_p1)) begin
            db_cnt_next = '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            accepted_next = code_sync_p1;
            db_cnt_next   = '0;
        end else begin
            db_cnt_next = db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            db_cnt        <= '0;
            accepted_code <= '0;
        end else begin
            db_cnt        <= db_cnt_next;
            accepted_code <= accepted_next;
        end
    end

    // Mode FSM and index selection. A mode change always takes priority
    // over a scan tick in the same cycle.
    always_comb begin
        state_next = i_Mode ? SCAN : DECODE;
        scan_next  = scan_idx;
        presc_next = presc;
        idx_target = accepted_code;
        case (state)
            DECODE: begin
                // Entering scan starts from the accepted code with a fresh
                // prescaler; otherwise scan state is simply kept cleared.
                scan_next  = i_Mode ? accepted_code : '0;
                presc_next = '0;
                idx_target = accepted_code;
            end
            SCAN: begin
                if (!i_Mode) begin
                    scan_next  = '0;
                    presc_next = '0;
                    idx_target = accepted_code;
                end else if (i_Enable) begin
                    if (presc == PS_W'(SCAN_PERIOD - 1)) begin
                        presc_next = '0;
                        scan_next  = scan_idx + CODE_WIDTH'(1);
                    end else begin
                        presc_next = presc + PS_W'(1);
                    end
                    idx_target = scan_next;
                end else begin
                    // Disabled: prescaler frozen, index held.
                    idx_target = scan_idx;
                end
            end
            default: begin
                state_next = DECODE;
            end
        endcase
        index_next   = i_Enable ? idx_target : o_Index;
        one_hot_next = i_Enable ? onehot_of(index_next) : '0;
    end

    // Stage p2: output register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= DECODE;
            scan_idx  <= '0;
            presc     <= '0;
            o_Index   <= '0;
            o_One_Hot <= '0;
            o_Change  <= 1'b0;
        end else begin
            state     <= state_next;
            scan_idx  <= scan_next;
            presc     <= presc_next;
            o_Index   <= index_next;
            o_One_Hot <= one_hot_next;
            o_Change  <= (one_hot_next != o_One_Hot);
        end
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter CODE_WIDTH, default 2, meaning: code input width; legal range 1..5.
REQ-002 Parameter OUTPUTS, default 2**CODE_WIDTH, meaning: one-hot output width; derived from CODE_WIDTH and not overridden.
REQ-003 Parameter DEBOUNCE_CYCLES, default 250000, meaning: consecutive stable cycles before a code is accepted (10 ms at 25 MHz); legal minimum 1.
REQ-004 Parameter SCAN_PERIOD, default 12500000, meaning: cycles per step in scan mode; legal minimum 2.
REQ-005 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-006 Port i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-007 Port i_Rst  input  1  synchronous active-high reset.
REQ-008 Port i_Code  input  CODE_WIDTH  raw switch code, asynchronous, may bounce; bit 0 is the LSB.
REQ-009 Port i_Mode  input  1  0 = decode the debounced code, 1 = auto-scan; synchronous level.
REQ-010 Port i_Enable  input  1  1 = outputs active, 0 = all outputs dark; synchronous level.
REQ-011 Port o_One_Hot  output  OUTPUTS  registered one-hot decode; bit n is high when the index is n.
REQ-012 Port o_Index  output  CODE_WIDTH  registered index currently decoded.
REQ-013 Port o_Change  output  1  one-cycle pulse when o_One_Hot takes a new value.

Function
REQ-014 i_Code SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce: the stable counter SHALL clear when the synchronized code changes or equals the accepted code, and SHALL otherwise increment.
REQ-016 Debounce: when the counter would reach DEBOUNCE_CYCLES, the accepted code SHALL load the synchronized code and the counter SHALL clear.
REQ-017 A code change held stable SHALL appear on o_One_Hot exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it (2 sync, DEBOUNCE_CYCLES count, 1 output register).
REQ-018 A bounce shorter than DEBOUNCE_CYCLES cycles SHALL leave the accepted code and the outputs unchanged.
REQ-019 The state machine SHALL have two states, DECODE and SCAN, selected by i_Mode each cycle.
REQ-020 DECODE state: the next index SHALL equal the accepted code.
REQ-021 Entering SCAN from DECODE: the scan index SHALL load the accepted code and the prescaler SHALL clear.
REQ-022 SCAN state: the prescaler SHALL count 0..SCAN_PERIOD-1; on the terminal count the index SHALL increment and wrap from OUTPUTS-1 to 0.
REQ-023 Leaving SCAN: o_Index SHALL show the accepted code on the next edge, and scan state SHALL be discarded.
REQ-024 If a mode change and a scan tick occur in the same cycle, the mode change SHALL win and no increment SHALL occur.
REQ-025 When i_Enable=0, o_One_Hot SHALL be all zeros on the next edge, o_Index SHALL hold, and the prescaler SHALL freeze; debouncing SHALL continue.
REQ-026 When i_Enable=1, o_One_Hot SHALL equal 1 shifted left by the next o_Index value, so exactly one bit is high.
REQ-027 o_Change SHALL be high for exactly the cycle in which registered o_One_Hot differs from its previous value, including enable transitions.
REQ-028 All arithmetic SHALL be unsigned; the scan index wraps modulo OUTPUTS, and the prescaler is ceil(log2(SCAN_PERIOD)) bits wide.

Reset
REQ-029 While i_Rst=1 on an edge: o_One_Hot=0, o_Index=0, o_Change=0, accepted code=0, synchronizers=0, counters=0, state=DECODE.
REQ-030 Reset SHALL dominate i_Mode, i_Enable and any debounce or scan activity in progress, including mid-scan and mid-debounce.
REQ-031 On the first edge after reset release with i_Enable=1, o_One_Hot SHALL become bit 0 and o_Change SHALL pulse once.

Verification (CODE_WIDTH=2, DEBOUNCE_CYCLES=4, SCAN_PERIOD=3)
REQ-032 Reset, then hold i_Code=2'b10 with Mode=0 and Enable=1 -> o_One_Hot=4'b0001 at cycle 1, then 4'b0100 exactly 7 edges after the i_Code change, with one o_Change pulse at each update.
REQ-033 From i_Code=00, glitch to 11 for 3 cycles then back -> o_One_Hot stays 4'b0001 and o_Change stays 0.
REQ-034 Accepted code 01, set i_Mode=1 -> o_Index sequence 1,2,3,0,1, stepping every 3 cycles, with one o_Change pulse per step.
REQ-035 In SCAN at index 3, drop i_Enable for 5 cycles then restore -> o_One_Hot=0 during the gap, then 4'b1000 on restore with the prescaler resumed, and o_Change pulses on both transitions.
REQ-036 Assert i_Rst mid-scan at index 2 with i_Code=11 accepted -> all outputs 0 on the next edge, then bit 0, then 4'b1000 after 7 edges.
